stream_demux: RTL and testbench



---
 rtl/stream_demux.sv | 157 +++++++++++++++
 tb/tb_stream_demux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux
// ------------
// Registered 1-to-2 stream demultiplexer. Each word on the input valid/ready
// stream is steered by its in_sel bit into one of two small FIFOs. Each FIFO
// drives its own output stream, so a stalled consumer on one side only blocks
// producer words that are aimed at that side.
//
// Handshake: a word moves on a rising edge exactly when valid and ready are
// both high on that interface. The producer holds in_data/in_sel/in_valid
// stable until the word is taken. A consumer may raise or lower outX_ready
// freely. in_ready is combinational from in_sel, flush and the occupancy of
// the selected FIFO. Nothing passes through in the same cycle, so a full
// FIFO never accepts a push even while it is being popped.
//
// Parameters:
//   n      data width in bits (>= 1)
//   DEPTH  entries per output FIFO (power of two, >= 2)
//
// Ports:
//   clk, rst              single clock; asynchronous active-high reset
//   flush                 synchronous clear of both FIFOs (pointers, counts)
//   in_data/in_sel        input word and its destination (0 -> out0, 1 -> out1)
//   in_valid/in_ready     input handshake
//   outX_data/outX_valid  FIFO head word / FIFO not empty
//   outX_ready            consumer takes the head word
//   cnt0/cnt1             16-bit wrapping count of words delivered per output.
//                         These exist only when STREAM_DEMUX_STATS_EN is defined.
//                         They clear on rst and are not cleared by flush.
module stream_demux #(
    parameter int n     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [n-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [n-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Index 0 belongs to out0 and index 1 belongs to out1.
    logic [n-1:0]  mem_q  [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_rdy;

    assign out_rdy = {out1_ready, out0_ready};

    always_comb begin
        full     = '0;
        push     = '0;
        pop      = '0;
        in_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            full[i] = (cnt_q[i] == CW'(DEPTH));
        end
        in_ready = !flush && !full[in_sel];
        for (int i = 0; i < 2; i++) begin
            push[i] = in_valid && in_ready && (in_sel == 1'(i));
            // A pop in a flush cycle is discarded, together with any push.
            pop[i]  = !flush && (cnt_q[i] != '0) && out_rdy[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (flush) begin
                wptr_d[i] = '0;
                rptr_d[i] = '0;
                cnt_d[i]  = '0;
            end else begin
                // The pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
                if (push[i]) wptr_d[i] = wptr_q[i] + PW'(1);
                if (pop[i])  rptr_d[i] = rptr_q[i] + PW'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                    2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                // Storage is cleared on reset so that the idle outputs read as zero.
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
                if (push[i]) begin
                    mem_q[i][wptr_q[i]] <= in_data;
                end
            end
        end
    end

    // The head word is shown even when the FIFO is empty, which gives stale data.
    assign out0_data  = mem_q[0][rptr_q[0]];
    assign out1_data  = mem_q[1][rptr_q[1]];
    assign out0_valid = (cnt_q[0] != '0);
    assign out1_valid = (cnt_q[1] != '0);

`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0] stat_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q[0] <= '0;
            stat_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    assign cnt0 = stat_q[0];
    assign cnt1 = stat_q[1];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux. Directed scenarios are followed by a randomized phase.
// A reference model keeps the contents of each output FIFO as a plain queue of
// words. Each output is valid whenever its queue is non-empty, and its head word
// must match the front of the queue. in_ready is high when the queue for the
// selected output is shorter than DEPTH and flush is low.
module tb_stream_demux;

  localparam int N     = 5;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [N-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0]  cnt0;
  logic [15:0]  cnt1;
`endif

  stream_demux #(.n(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected words per output, in delivery order
  logic [N-1:0] exp_q0[$];
  logic [N-1:0] exp_q1[$];
  logic [15:0]  exp_cnt0 = '0;
  logic [15:0]  exp_cnt1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: samples on the falling edge, compares against the model, and then
  // advances the model to the state it should have after the next rising edge
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_cnt0 = '0;
      exp_cnt1 = '0;
      check("rst out0_valid", out0_valid, 0);
      check("rst out1_valid", out1_valid, 0);
    end else begin
      check("out0_valid", out0_valid, exp_q0.size() > 0);
      check("out1_valid", out1_valid, exp_q1.size() > 0);
      if (exp_q0.size() > 0) check("out0_data", out0_data, exp_q0[0]);
      if (exp_q1.size() > 0) check("out1_data", out1_data, exp_q1[0]);
      exp_rdy = !flush && ((in_sel ? exp_q1.size() : exp_q0.size()) < DEPTH);
      check("in_ready", in_ready, exp_rdy);
`ifdef STREAM_DEMUX_STATS_EN
      check("cnt0", cnt0, exp_cnt0);
      check("cnt1", cnt1, exp_cnt1);
`endif
      if (flush) begin
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        if (out0_ready && exp_q0.size() > 0) begin
          void'(exp_q0.pop_front());
          exp_cnt0 = exp_cnt0 + 16'd1;
        end
        if (out1_ready && exp_q1.size() > 0) begin
          void'(exp_q1.pop_front());
          exp_cnt1 = exp_cnt1 + 16'd1;
        end
        if (in_valid && exp_rdy) begin
          if (in_sel) exp_q1.push_back(in_data);
          else        exp_q0.push_back(in_data);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic s, input logic [N-1:0] d,
                       input logic r0, input logic r1, input logic fl);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    flush      = fl;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out0_valid", out0_valid, 0);
    check("async rst out1_valid", out1_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("after rst in_ready", in_ready, 1);
  endtask

  initial begin
    logic acc;
    rst        = 1'b1;
    flush      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out0_data", out0_data, 0);
    check("reset out1_data", out1_data, 0);
    rst = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);

    // routing
    drive(1'b1, 1'b0, 5'b10101, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'b01010, 1'b1, 1'b1, 1'b0);
    #1;
    check("route out0_data", out0_data, 5'b10101);
    check("route out0_valid", out0_valid, 1);
    idle(3);

    // back-pressure on out0
    drive(1'b1, 1'b0, 5'b00001, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'b00010, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    #1;
    check("bp in_ready sel0", in_ready, 0);
    in_sel = 1'b1;
    #1;
    check("bp in_ready sel1", in_ready, 1);
    drive(1'b1, 1'b1, 5'b11111, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    #1;
    check("bp out1_data", out1_data, 5'b11111);
    idle(3);

    // full, wrap and order on out1
    drive(1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    check("full pop no push", in_ready, 0);
    drive(1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    idle(3);

    // flush with a push attempt
    drive(1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    #1;
    check("flush in_ready", in_ready, 0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("flush out0_valid", out0_valid, 0);
    check("flush out1_valid", out1_valid, 0);

    // asynchronous reset with words queued
    drive(1'b1, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    async_reset();

    // delivery counters
    drive(1'b1, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd21, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd22, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd23, 1'b1, 1'b1, 1'b0);
    idle(2);
    #1;
`ifdef STREAM_DEMUX_STATS_EN
    check("stats cnt0", cnt0, 16'd3);
    check("stats cnt1", cnt1, 16'd1);
`endif
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(1);
    #1;
`ifdef STREAM_DEMUX_STATS_EN
    check("flush keeps cnt0", cnt0, 16'd3);
    check("flush keeps cnt1", cnt1, 16'd1);
`endif
    async_reset();
`ifdef STREAM_DEMUX_STATS_EN
    check("rst clears cnt0", cnt0, 16'd0);
    check("rst clears cnt1", cnt1, 16'd0);
`endif

    // randomized traffic; the producer holds its word until it is accepted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = N'($urandom_range(0, (1 << N) - 1));
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 40) == 0);
    end

    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
